pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the decode stage's `stall`, `hazStall` and `doBranch` inputs, and the fetch-stage hold.
- It shadows in-flight destination registers to detect RAW hazards. Only register-file bypass exists (WB write is visible to an ID read in the same cycle); there is no EX/MEM forwarding.
- It arbitrates data-memory wait, branch flush and halt drain.

Parameters:
- REG_W, 3, register-select width
- DRAIN_CYC, 3, cycles to retire EX/MEM/WB after halt accepted
- CNT_W, 16, stall-cycle counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- idValid  in  1  ID holds a real instruction
- idRead1Sel  in  REG_W  ID source 1 (instr[10:8])
- idRead1Use  in  1  source 1 read by instruction
- idRead2Sel  in  REG_W  ID source 2 (instr[7:5])
- idRead2Use  in  1  source 2 read by instruction
- idRegWrt  in  1  ID instruction writes RF
- idWriteReg  in  REG_W  ID destination
- idHalt  in  1  ID instruction is HALT
- exBrTaken  in  1  EX resolved taken branch/jump
- memBusy  in  1  data memory not ready
- stall  out  1  hold IF/ID, zero ID control (bubble)
- hazStall  out  1  stall cause is RAW hazard
- doBranch  out  1  flush IF/ID this cycle
- haltDone  out  1  pipeline drained after HALT
- stallCnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst=0, async): state=RUN; shadow entries invalid; stallCnt=0; drain counter=0. All outputs 0.
- Shadow pipeline: two registered entries {v, dst}, exEnt and memEnt. Each cycle that is not frozen: memEnt<=exEnt; exEnt<=decode entry, or invalid on bubble/flush. Decode entry = {idValid&idRegWrt, idWriteReg}.
- Hazard (combinational): raw = idValid & ((idRead1Use & hit(idRead1Sel)) | (idRead2Use & hit(idRead2Sel))). hit(r) = (exEnt.v & exEnt.dst==r) | (memEnt.v & memEnt.dst==r).
- Priority per cycle, highest first: memBusy > exBrTaken > raw > idHalt.
- States: RUN, MEMWAIT, DRAIN, HALTED.
- RUN:
  - memBusy: stall=1, hazStall=0, doBranch=0; shadow frozen; next MEMWAIT.
  - Else exBrTaken: doBranch=1 (combinational, same cycle), stall=0; exEnt<=invalid; raw and idHalt ignored.
  - Else raw: stall=1, hazStall=1; exEnt<=invalid; memEnt advances.
  - Else idHalt&idValid: accepted; exEnt<=invalid; drain<=DRAIN_CYC; next DRAIN; stall=0 this cycle.
- MEMWAIT: stall=1, shadow frozen, while memBusy=1. When memBusy=0, re-evaluate with RUN rules in that same cycle, and next state follows those rules.
- DRAIN:
  - stall=1 (no new fetch).
  - Drain decrements on each cycle with memBusy=0; memBusy freezes drain and shadow.
  - exBrTaken is ignored (the branch is older than the halt, so already resolved).
  - When drain reaches 0: next HALTED.
- HALTED: stall=1, haltDone=1, shadow invalid. Exit only by reset.
- stallCnt: +1 on every cycle with stall=1; saturates at all-ones; never wraps.
- Back-to-back hazards: stall persists until the producer leaves memEnt (at most 2 cycles for EX distance).
- Destination r0 is not special; matching is on all registers.
- Reset mid-stall/drain returns to RUN with empty shadow the next active cycle; no residual bubble.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - state encoding RUN=0, MEMWAIT=1, DRAIN=2, HALTED=3
  - DRAIN_CYC default
  - shadow-entry struct {v, dst}
- One sub-module, `hazard_scoreboard`: owns exEnt/memEnt registers, advance/freeze/invalidate controls, and the hit compare for both sources. The top holds the FSM, priority logic, drain counter and stallCnt.

Test Plan:
- Load-use/RAW: ADD r3 (idRegWrt=1, dst=3) followed next cycle by use of r3 (read1Sel=3, use=1) -> stall=hazStall=1 for exactly 2 cycles, then 0. stallCnt=2.
- Distance-2 dependency: producer dst=5, one independent instr, then consumer of r5 -> exactly 1 stall cycle. Distance 3 -> 0 stall cycles (bypass).
- Branch over hazard: exBrTaken=1 in the same cycle raw=1 -> doBranch=1, stall=0, exEnt invalid. The next cycle's consumer of the same reg does not stall.
- Memory wait: memBusy high 4 cycles during a pending RAW -> stall=1, hazStall=0 for those 4 cycles with shadow frozen. The RAW stall then resumes for its remaining cycles.
- Halt: idHalt at cycle N with memBusy=0 -> stall=1 at N+1..N+3, haltDone=1 from N+4 onward. A memBusy pulse during drain extends haltDone by the pulse length.
- Async reset: rst=0 asserted mid-DRAIN (between edges) -> all outputs 0 immediately. After release, state=RUN, no stall with idValid=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM encoding,
// drain default and the in-flight destination shadow entry.
package pipe_ctrl_pkg;

  localparam int unsigned REG_SEL_W     = 3;
  localparam int unsigned DRAIN_CYC_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  typedef struct packed {
    logic                 v;
    logic [REG_SEL_W-1:0] dst;
  } shadow_ent_t;

  function automatic logic ent_hit(input shadow_ent_t e, input logic [REG_SEL_W-1:0] r);
    return e.v && (e.dst == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadows destinations of the instructions in EX and MEM and reports
// whether either ID source matches one of them.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_advance,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  shadow_ent_t          i_dec,
  input  logic [REG_SEL_W-1:0] i_sel1,
  input  logic [REG_SEL_W-1:0] i_sel2,
  output logic                 o_hit1_c,
  output logic                 o_hit2_c
);

  shadow_ent_t r_ex;
  shadow_ent_t r_mem;

  // Freeze holds both entries; a bubble or flush shifts an empty slot into EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else if (i_clear) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else if (i_advance) begin
      r_mem <= r_ex;
      r_ex  <= i_load ? i_dec : '0;
    end
  end

  assign o_hit1_c = ent_hit(r_ex, i_sel1) | ent_hit(r_mem, i_sel1);
  assign o_hit2_c = ent_hit(r_ex, i_sel2) | ent_hit(r_mem, i_sel2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: RAW hazard stall,
// data-memory wait, branch flush and HALT drain, plus a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W     = REG_SEL_W,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idValid,
  input  logic [REG_W-1:0] idRead1Sel,
  input  logic             idRead1Use,
  input  logic [REG_W-1:0] idRead2Sel,
  input  logic             idRead2Use,
  input  logic             idRegWrt,
  input  logic [REG_W-1:0] idWriteReg,
  input  logic             idHalt,
  input  logic             exBrTaken,
  input  logic             memBusy,
  output logic             stall,
  output logic             hazStall,
  output logic             doBranch,
  output logic             haltDone,
  output logic [CNT_W-1:0] stallCnt
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  state_e             r_state;
  state_e             w_next;
  logic [DRAIN_W-1:0] r_drain;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic [CNT_W-1:0]   r_cnt;
  shadow_ent_t        w_dec;
  logic               w_hit1;
  logic               w_hit2;
  logic               w_raw;
  logic               w_adv;
  logic               w_load;
  logic               w_clear;
  logic               w_stall;
  logic               w_haz;
  logic               w_br;
  logic               w_done;

  assign w_dec = '{v: idValid & idRegWrt, dst: REG_SEL_W'(idWriteReg)};

  hazard_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_adv),
    .i_load    (w_load),
    .i_clear   (w_clear),
    .i_dec     (w_dec),
    .i_sel1    (REG_SEL_W'(idRead1Sel)),
    .i_sel2    (REG_SEL_W'(idRead2Sel)),
    .o_hit1_c  (w_hit1),
    .o_hit2_c  (w_hit2)
  );

  assign w_raw = idValid & ((idRead1Use & w_hit1) | (idRead2Use & w_hit2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_drain <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= w_drain_nxt;
      if (w_stall && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // MEMWAIT shares RUN's rules: once memBusy drops it re-arbitrates in the same cycle.
  always_comb begin
    w_next      = r_state;
    w_drain_nxt = r_drain;
    w_stall     = 1'b0;
    w_haz       = 1'b0;
    w_br        = 1'b0;
    w_done      = 1'b0;
    w_adv       = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_RUN, ST_MEMWAIT: begin
        if (memBusy) begin
          w_stall = 1'b1;
          w_next  = ST_MEMWAIT;
        end else begin
          w_adv  = 1'b1;
          w_next = ST_RUN;
          if (exBrTaken) begin
            w_br = 1'b1;
          end else if (w_raw) begin
            w_stall = 1'b1;
            w_haz   = 1'b1;
          end else if (idHalt && idValid) begin
            w_next      = ST_DRAIN;
            w_drain_nxt = DRAIN_W'(DRAIN_CYC);
          end else begin
            w_load = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        w_stall = 1'b1;
        if (!memBusy) begin
          w_adv = 1'b1;
          if (r_drain <= DRAIN_W'(1)) begin
            w_next      = ST_HALTED;
            w_drain_nxt = '0;
          end else begin
            w_drain_nxt = r_drain - DRAIN_W'(1);
          end
        end
      end
      ST_HALTED: begin
        w_stall = 1'b1;
        w_done  = 1'b1;
        w_clear = 1'b1;
      end
      default: w_next = ST_RUN;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted.
  assign stall    = rst & w_stall;
  assign hazStall = rst & w_haz;
  assign doBranch = rst & w_br;
  assign haltDone = rst & w_done;
  assign stallCnt = r_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        idValid;
  logic [2:0]  idRead1Sel;
  logic        idRead1Use;
  logic [2:0]  idRead2Sel;
  logic        idRead2Use;
  logic        idRegWrt;
  logic [2:0]  idWriteReg;
  logic        idHalt;
  logic        exBrTaken;
  logic        memBusy;
  logic        stall;
  logic        hazStall;
  logic        doBranch;
  logic        haltDone;
  logic [15:0] stallCnt;

  typedef struct {
    string       name;
    logic [3:0]  flags;  // {stall, hazStall, doBranch, haltDone}
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;
  int   exp_cnt;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .idValid    (idValid),
    .idRead1Sel (idRead1Sel),
    .idRead1Use (idRead1Use),
    .idRead2Sel (idRead2Sel),
    .idRead2Use (idRead2Use),
    .idRegWrt   (idRegWrt),
    .idWriteReg (idWriteReg),
    .idHalt     (idHalt),
    .exBrTaken  (exBrTaken),
    .memBusy    (memBusy),
    .stall      (stall),
    .hazStall   (hazStall),
    .doBranch   (doBranch),
    .haltDone   (haltDone),
    .stallCnt   (stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input string nm, input logic rs, input logic iv,
                       input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2,
                       input logic wr, input logic [2:0] wd, input logic h,
                       input logic br, input logic mb, input logic [3:0] ex);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rs; idValid = iv;
    idRead1Sel = s1; idRead1Use = u1; idRead2Sel = s2; idRead2Use = u2;
    idRegWrt = wr; idWriteReg = wd; idHalt = h; exBrTaken = br; memBusy = mb;
    e.name  = nm;
    e.flags = ex;
    if (!rs) exp_cnt = 0;
    e.cnt = 16'(exp_cnt);
    q.push_back(e);
    if (rs && ex[3]) exp_cnt++;
  endtask

  task automatic ins(input string nm, input logic [2:0] s1, input logic u1,
                     input logic wr, input logic [2:0] wd, input logic br,
                     input logic mb, input logic [3:0] ex);
    drive(nm, 1'b1, 1'b1, s1, u1, 3'd0, 1'b0, wr, wd, 1'b0, br, mb, ex);
  endtask

  task automatic bub(input string nm, input logic br, input logic mb, input logic [3:0] ex);
    drive(nm, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, br, mb, ex);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    logic [3:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {stall, hazStall, doBranch, haltDone};
        n_vec++;
        if (got !== e.flags || stallCnt !== e.cnt) begin
          n_err++;
          $display("FAIL %s: got stall/haz/br/done=%b cnt=%0d, want %b cnt=%0d",
                   e.name, got, stallCnt, e.flags, e.cnt);
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; exp_cnt = 0;
    rst = 1'b0; idValid = 1'b0; idRead1Sel = '0; idRead1Use = 1'b0;
    idRead2Sel = '0; idRead2Use = 1'b0; idRegWrt = 1'b0; idWriteReg = '0;
    idHalt = 1'b0; exBrTaken = 1'b0; memBusy = 1'b0;

    drive("reset0", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive("reset1", 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 4'b0000);
    bub("idle", 1'b0, 1'b0, 4'b0000);

    // Load-use, distance 1: two stall cycles.
    ins("lu_prod",  3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 4'b0000);
    ins("lu_use1",  3'd3, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 4'b1100);
    ins("lu_use2",  3'd3, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 4'b1100);
    ins("lu_go",    3'd3, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 4'b0000);
    bub("lu_b1", 1'b0, 1'b0, 4'b0000);
    bub("lu_b2", 1'b0, 1'b0, 4'b0000);

    // Distance 2 via source 2: one stall cycle.
    ins("d2_prod",  3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 4'b0000);
    ins("d2_indep", 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000);
    drive("d2_use1", 1'b1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b1100);
    drive("d2_go",   1'b1, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Distance 3: register-file bypass, no stall.
    ins("d3_prod",  3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 4'b0000);
    ins("d3_ind1",  3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000);
    ins("d3_ind2",  3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000);
    ins("d3_use",   3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000);

    // r0 is an ordinary register for matching.
    ins("r0_prod",  3'd1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'b0000);
    ins("r0_use1",  3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'b1100);
    ins("r0_use2",  3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'b1100);
    ins("r0_go",    3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000);

    // Branch beats RAW; flushed ID writer (r7) must not enter the shadow.
    ins("br_prod",  3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 4'b0000);
    ins("br_instr", 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000);
    ins("br_flush", 3'd4, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 4'b0010);
    drive("br_tgt", 1'b1, 1'b1, 3'd4, 1'b1, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Memory wait over a pending RAW, then the RAW finishes its two cycles.
    ins("mw_prod",  3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 4'b0000);
    ins("mw_w1",    3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'b1000);
    ins("mw_w2",    3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'b1000);
    ins("mw_w3",    3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'b1000);
    ins("mw_w4",    3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'b1000);
    ins("mw_raw1",  3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'b1100);
    ins("mw_raw2",  3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'b1100);
    ins("mw_go",    3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000);
    bub("mw_busybr", 1'b1, 1'b1, 4'b1000);
    bub("mw_br",     1'b1, 1'b0, 4'b0010);

    // Halt with a one-cycle memBusy pulse during drain; branch ignored in drain.
    drive("h_accept", 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    bub("h_dr1",   1'b0, 1'b0, 4'b1000);
    bub("h_drmb",  1'b0, 1'b1, 4'b1000);
    bub("h_dr2",   1'b0, 1'b0, 4'b1000);
    bub("h_dr3br", 1'b1, 1'b0, 4'b1000);
    bub("h_done1", 1'b0, 1'b0, 4'b1001);
    bub("h_done2", 1'b1, 1'b0, 4'b1001);

    // Reset out of HALTED, then asynchronous reset mid-drain.
    drive("rst_h", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    bub("rst_h_rel", 1'b0, 1'b0, 4'b0000);
    drive("h2_accept", 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    bub("h2_dr1", 1'b0, 1'b0, 4'b1000);
    drive("rst_drain", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    bub("rst_rel", 1'b0, 1'b0, 4'b0000);
    ins("post_use", 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000);

    // Invalid ID slot never raises a hazard.
    ins("iv_prod", 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'b0000);
    drive("iv_none", 1'b1, 1'b0, 3'd1, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_queue: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
